// File: rtl/relm_fifo_mc.sv
// Multi-channel FIFO bank for the ReLM PUSH/POP ports.
// Each channel is an independent 2**WAD x WD FIFO with count, almost-full and lock.
module relm_fifo_mc #(
  parameter int NCH   = 2,
  parameter int WAD   = 4,
  parameter int WD    = 32,
  parameter int AFULL = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*(WD+1)-1:0]  push_d,
  output logic [NCH-1:0]         push_retry,
  input  logic [NCH*(WD+1)-1:0]  pop_d,
  output logic [NCH*(WD+1)-1:0]  pop_q,
  output logic [NCH*(WAD+1)-1:0] count_out,
  output logic [NCH-1:0]         afull_out
);

  localparam int DEPTH = 2**WAD;
  localparam logic [WAD:0] DEPTH_C = (WAD+1)'(DEPTH);
  localparam logic [WAD:0] AFULL_C = (WAD+1)'(AFULL);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic          wr_stb;
    logic [WD-1:0] wr_dat;
    logic          rd_req;
    logic          lk_set;
    logic          lk_clr;
    logic          dm_stb;

    logic [WAD:0]  wr;
    logic [WAD:0]  rd;
    logic [WAD:0]  rd_next;
    logic [WAD:0]  cnt;
    logic [WAD:0]  cnt_next;
    logic [WAD:0]  re_ext;
    logic [WAD:0]  we_ext;
    logic          empty;
    logic          full;
    logic          afull;
    logic          lock;
    logic          stb;
    logic          re;
    logic          we;
    logic          retry;
    logic [WD-1:0] mem [DEPTH];
    logic [WD-1:0] head;

    assign wr_stb = push_d[c*(WD+1)+WD];
    assign wr_dat = push_d[c*(WD+1) +: WD];
    assign rd_req = pop_d[c*(WD+1)+WD];
    assign lk_set = pop_d[c*(WD+1)+WD-1];
    assign lk_clr = pop_d[c*(WD+1)+WD-2];
    assign dm_stb = pop_d[c*(WD+1)];

    assign stb      = lock | dm_stb;
    assign re       = stb & rd_req & ~empty;
    assign retry    = full & ~re;
    assign we       = wr_stb & ~retry;
    assign re_ext   = (WAD+1)'(re);
    assign we_ext   = (WAD+1)'(we);
    assign rd_next  = rd + re_ext;
    assign cnt_next = cnt + we_ext - re_ext;

    // empty counts only words already in RAM before this edge,
    // so a word written now stays hidden for one cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr    <= '0;
        rd    <= '0;
        cnt   <= '0;
        empty <= 1'b1;
        full  <= 1'b0;
        afull <= 1'b0;
        lock  <= 1'b0;
      end else begin
        wr    <= wr + we_ext;
        rd    <= rd_next;
        cnt   <= cnt_next;
        empty <= (cnt - re_ext) == '0;
        full  <= cnt_next == DEPTH_C;
        afull <= cnt_next >= AFULL_C;
        if (lk_clr)      lock <= 1'b0;
        else if (lk_set) lock <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (we) mem[wr[WAD-1:0]] <= wr_dat;
      head <= mem[rd_next[WAD-1:0]];
    end

    assign pop_q[c*(WD+1) +: WD+1] =
      stb ? {empty, head} : {{WD{1'b0}}, ~empty};
    assign count_out[c*(WAD+1) +: WAD+1] = cnt;
    assign afull_out[c]  = afull;
    assign push_retry[c] = retry;
  end

endmodule
